// File: rtl/el2_fair_pkg.sv
// Shared constants for the EL2 fairness monitor: FSM encoding, fairness-set
// indices and the acceptance masks for the two- and three-set builds.
package el2_fair_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ACC   = 2'd2,
    STALL = 2'd3
  } state_e;

  localparam int SET_DIG   = 0;
  localparam int SET_O     = 1;
  localparam int SET_PAUSE = 2;

  localparam logic [2:0] ALL_2SET = 3'b011;
  localparam logic [2:0] ALL_3SET = 3'b111;

endpackage

// File: rtl/el2_stall_timer.sv
// Counts consecutive frozen sampled cycles; expired fires in the cycle the
// count reaches STALL_LIM so the caller can act on it that same edge.
module el2_stall_timer #(
  parameter int STALL_LIM = 15,
  parameter int STALLW    = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_en,
  input  logic hold_clr,
  input  logic frozen,
  output logic expired
);

  localparam logic [STALLW-1:0] LIM = STALLW'(STALL_LIM);

  logic [STALLW-1:0] count;
  logic [STALLW-1:0] count_nxt;

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    count_nxt = count;
    if (hold_clr)
      count_nxt = '0;
    else if (sample_en)
      count_nxt = frozen ? ((count == LIM) ? LIM : count + 1'b1) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count_nxt;
  end

  assign expired = (count_nxt == LIM);

endmodule

// File: rtl/el2_fair_monitor.sv
// Generalized-Buchi acceptance and sink detector for the EL2 walker.
// Define EL2_FAIR_PAUSE_SET_EN to add the pause==0 fairness set.
module el2_fair_monitor
  import el2_fair_pkg::*;
#(
  parameter int CNTW      = 8,
  parameter int STALL_LIM = 15,
  parameter int STALLW    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            sample_en,
  input  logic            colmsb,
  input  logic            collsb,
  input  logic            pause,
  output logic            accept,
  output logic [CNTW-1:0] epoch_cnt,
  output logic [2:0]      seen,
  output logic            stalled,
  output logic [1:0]      state
);

`ifdef EL2_FAIR_PAUSE_SET_EN
  localparam logic [2:0] ALL = ALL_3SET;
`else
  localparam logic [2:0] ALL = ALL_2SET;
`endif

  state_e     state_q;
  logic [1:0] prev_col;
  logic [2:0] hits;
  logic [2:0] seen_nxt;
  logic       complete;
  logic       frozen;
  logic       expired;

  // Masking with ALL keeps seen[2] at 0 when the pause set is disabled.
  always_comb begin
    hits = '0;
    if (sample_en) begin
      hits[SET_DIG]   = colmsb & collsb;
      hits[SET_O]     = colmsb & ~collsb;
      hits[SET_PAUSE] = ~pause;
      hits            = hits & ALL;
    end
  end

  assign seen_nxt = seen | hits;
  assign complete = sample_en && (seen_nxt == ALL);
  assign frozen   = ({colmsb, collsb} == prev_col) && !pause;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          prev_col <= '0;
    else if (sample_en) prev_col <= {colmsb, collsb};
  end

  el2_stall_timer #(
    .STALL_LIM (STALL_LIM),
    .STALLW    (STALLW)
  ) u_stall_timer (
    .clock     (clock),
    .reset     (reset),
    .sample_en (sample_en),
    .hold_clr  (state_q == IDLE),
    .frozen    (frozen),
    .expired   (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      seen      <= '0;
      accept    <= 1'b0;
      epoch_cnt <= '0;
      stalled   <= 1'b0;
    end else begin
      accept <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample_en && colmsb) begin
            state_q <= TRACK;
            seen    <= hits;
          end
        end
        TRACK, ACC: begin
          // A stall outranks an epoch completing on the same cycle.
          if (expired) begin
            state_q <= STALL;
            stalled <= 1'b1;
          end else if (complete) begin
            state_q <= ACC;
            seen    <= '0;
            accept  <= 1'b1;
            if (epoch_cnt != '1) epoch_cnt <= epoch_cnt + 1'b1;
          end else begin
            state_q <= TRACK;
            seen    <= seen_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule
